// File: rtl/mmu_4x4.sv
// Weight-stationary 4x4 systolic multiply-accumulate array: 8-bit operands, 32-bit column sums.
// Define MMU_SIGNED_EN for two's-complement operands; the default build is unsigned.
module mmu_4x4 (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         control,
  input  logic [31:0]  wt_arr,
  input  logic [31:0]  data_arr,
  output logic [127:0] acc_out
);

  logic [7:0]  w_q [4][4];
  logic [7:0]  w_d [4][4];
  logic [7:0]  d_q [4][4];
  logic [7:0]  d_d [4][4];
  logic [31:0] p_q [4][4];
  logic [31:0] p_d [4][4];
  logic [7:0]  din [4][4];

  function automatic logic [31:0] mac(input logic [31:0] pin,
                                      input logic [7:0]  a,
                                      input logic [7:0]  b);
`ifdef MMU_SIGNED_EN
    logic signed [15:0] prod;
    prod = $signed(a) * $signed(b);
    return pin + {{16{prod[15]}}, prod};
`else
    logic [15:0] prod;
    prod = a * b;
    return pin + {16'd0, prod};
`endif
  endfunction

  always_comb begin
    w_d = w_q;
    d_d = d_q;
    p_d = p_q;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        din[r][c] = (c == 0) ? data_arr[8*r +: 8] : d_q[r][(c == 0) ? 0 : c-1];
      end
    end
    if (control) begin
      // Weights shift down one row per load cycle; the first word loaded ends in row 3.
      for (int c = 0; c < 4; c++) begin
        w_d[0][c] = wt_arr[8*c +: 8];
        for (int r = 1; r < 4; r++) w_d[r][c] = w_q[r-1][c];
      end
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          d_d[r][c] = 8'd0;
          p_d[r][c] = 32'd0;
        end
      end
    end else begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          d_d[r][c] = din[r][c];
          p_d[r][c] = mac((r == 0) ? 32'd0 : p_q[(r == 0) ? 0 : r-1][c], din[r][c], w_q[r][c]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          w_q[r][c] <= 8'd0;
          d_q[r][c] <= 8'd0;
          p_q[r][c] <= 32'd0;
        end
      end
    end else begin
      w_q <= w_d;
      d_q <= d_d;
      p_q <= p_d;
    end
  end

  always_comb begin
    acc_out = '0;
    for (int c = 0; c < 4; c++) acc_out[32*c +: 32] = p_q[3][c];
  end

endmodule

// File: tb/tb_mmu_4x4.sv
// Table-driven bench for mmu_4x4: one record per clock cycle, acc_out compared mid-cycle.
module tb_mmu_4x4;

  logic         clk;
  logic         rst_n;
  logic         control;
  logic [31:0]  wt_arr;
  logic [31:0]  data_arr;
  logic [127:0] acc_out;

  mmu_4x4 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .control  (control),
    .wt_arr   (wt_arr),
    .data_arr (data_arr),
    .acc_out  (acc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst_n;
    logic         ctrl;
    logic [31:0]  wt;
    logic [31:0]  data;
    logic [127:0] exp;
  } vec_t;

  vec_t tv[$];
  int   checks;
  int   passed;
  int   base;

`ifdef MMU_SIGNED_EN
  localparam logic [31:0] MAXV = 32'h0000_0004;
`else
  localparam logic [31:0] MAXV = 32'h0003_F804;
`endif

  function automatic void add(input logic r, input logic c,
                              input logic [31:0] wt, input logic [31:0] data);
    vec_t v;
    v.rst_n = r;
    v.ctrl  = c;
    v.wt    = wt;
    v.data  = data;
    v.exp   = '0;
    tv.push_back(v);
  endfunction

  function automatic void comp(input logic [31:0] data);
    add(1'b1, 1'b0, 32'd0, data);
  endfunction

  function automatic void idle(input int n);
    for (int i = 0; i < n; i++) comp(32'd0);
  endfunction

  function automatic void load(input logic [31:0] wt);
    add(1'b1, 1'b1, wt, 32'd0);
  endfunction

  function automatic void set_exp(input int idx, input int col, input logic [31:0] val);
    tv[idx].exp[32*col +: 32] = val;
  endfunction

  task automatic check(input string name, input logic [127:0] exp);
    checks++;
    if (acc_out !== exp)
      $display("FAIL %s acc_out got %h expected %h", name, acc_out, exp);
    else
      passed++;
  endtask

  initial begin
    checks   = 0;
    passed   = 0;
    rst_n    = 1'b0;
    control  = 1'b0;
    wt_arr   = '0;
    data_arr = '0;

    // Reset held with random control and operands: array must read zero.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      rst_n    = 1'b0;
      control  = 1'($urandom_range(0, 1));
      wt_arr   = $urandom;
      data_arr = $urandom;
      @(negedge clk);
      if (i > 0) check("reset_hold", '0);
    end

    // Reset beats a simultaneous load; weights stay zero so ones produce nothing.
    add(1'b0, 1'b1, 32'hA5A5_A5A5, 32'hFFFF_FFFF);
    for (int i = 0; i < 6; i++) comp(32'hFFFF_FFFF);
    idle(4);

    // Rows 3..0 end up holding words 1..4 in load order.
    load(32'h0102_0403);
    load(32'h0704_0102);
    load(32'h0301_0203);
    load(32'h0502_0304);

    // Single all-ones vector fed in skew straight after the 4th load cycle.
    base = tv.size();
    comp(32'h0000_0001); comp(32'h0000_0100); comp(32'h0001_0000); comp(32'h0100_0000);
    idle(5);
    set_exp(base+4, 0, 32'hC);
    set_exp(base+5, 1, 32'hA);
    set_exp(base+6, 2, 32'h9);
    set_exp(base+7, 3, 32'h10);

    // Back-to-back vectors: all-1 then all-2.
    base = tv.size();
    comp(32'h0000_0001); comp(32'h0000_0102); comp(32'h0001_0200);
    comp(32'h0102_0000); comp(32'h0200_0000);
    idle(5);
    set_exp(base+4, 0, 32'hC);
    set_exp(base+5, 0, 32'h18); set_exp(base+5, 1, 32'hA);
    set_exp(base+6, 1, 32'h14); set_exp(base+6, 2, 32'h9);
    set_exp(base+7, 2, 32'h12); set_exp(base+7, 3, 32'h10);
    set_exp(base+8, 3, 32'h20);

    // Row 0 alone exposes the last-loaded word 0x05020304.
    base = tv.size();
    comp(32'h0000_0001);
    idle(8);
    set_exp(base+4, 0, 32'h4);
    set_exp(base+5, 1, 32'h3);
    set_exp(base+6, 2, 32'h2);
    set_exp(base+7, 3, 32'h5);

    // Row 3 alone (value 2) exposes the first-loaded word 0x01020403.
    base = tv.size();
    comp(32'h0); comp(32'h0); comp(32'h0); comp(32'h0200_0000);
    idle(8);
    set_exp(base+4, 0, 32'h6);
    set_exp(base+5, 1, 32'h8);
    set_exp(base+6, 2, 32'h4);
    set_exp(base+7, 3, 32'h2);

    // Vector in flight killed by a reload of all-0xFF weights; everything reads 0.
    comp(32'h0000_0001); comp(32'h0000_0100);
    add(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0001_0000);
    add(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0100_0000);
    load(32'hFFFF_FFFF);
    load(32'hFFFF_FFFF);

    // Max operands against the new weights.
    base = tv.size();
    comp(32'h0000_00FF); comp(32'h0000_FF00); comp(32'h00FF_0000); comp(32'hFF00_0000);
    idle(5);
    for (int c = 0; c < 4; c++) set_exp(base+4+c, c, MAXV);

    // Reset mid-compute discards partials and weights.
    comp(32'h0000_00FF); comp(32'h0000_FF00);
    add(1'b0, 1'b0, 32'd0, 32'h00FF_0000);
    comp(32'hFF00_0000);
    idle(6);
    comp(32'h0000_0001); comp(32'h0000_0100); comp(32'h0001_0000); comp(32'h0100_0000);
    idle(8);

`ifdef MMU_SIGNED_EN
    load(32'h0); load(32'h0); load(32'h0); load(32'h0000_0003);
    base = tv.size();
    comp(32'h0000_00FF);
    idle(6);
    set_exp(base+4, 0, 32'hFFFF_FFFD);
`endif

    for (int i = 0; i < tv.size(); i++) begin
      @(posedge clk); #1;
      rst_n    = tv[i].rst_n;
      control  = tv[i].ctrl;
      wt_arr   = tv[i].wt;
      data_arr = tv[i].data;
      @(negedge clk);
      check($sformatf("vec%0d", i), tv[i].exp);
    end

    // Compute-to-load while a result is on the bus: bus clears next cycle.
    @(posedge clk); #1;
    rst_n = 1'b1; control = 1'b1; wt_arr = 32'h0101_0101; data_arr = '0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    control = 1'b0; data_arr = 32'h0000_0002;
    @(posedge clk); #1;
    data_arr = '0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("col0_before_kill", {96'd0, 32'h2});
    @(posedge clk); #1;
    control = 1'b1;
    @(negedge clk);
    check("col1_visible", {64'd0, 32'h2, 32'h0});
    @(posedge clk); #1;
    @(negedge clk);
    check("killed_by_load", '0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
